// File: rtl/data_path_ctrl.sv
// Moore controller sequencing data_path through load, iterate and finalize phases.
// Optional debug ports (dbg_state, dbg_cycles) are enabled by defining DATA_PATH_CTRL_DBG_EN.
module data_path_ctrl #(
  parameter int unsigned MAX_ITER = 1024,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      output2,
  input  logic [31:0]      output5,
  output logic             Enable3,
  output logic             Enable6,
  output logic             Enable7,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] iter_count
`ifdef DATA_PATH_CTRL_DBG_EN
  ,
  output logic [2:0]       dbg_state,
  output logic [31:0]      dbg_cycles
`endif
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCheck = 3'd1,
    StInit  = 3'd2,
    StTest  = 3'd3,
    StLoop  = 3'd4,
    StFinal = 3'd5,
    StDone  = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] MaxIter = CNT_W'(MAX_ITER);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             timeout_q, timeout_d;

  // Only bit 0 of output5 carries the loop-continue condition.
  logic unused_status;
  assign unused_status = ^output5[31:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      iter_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    timeout_d = timeout_q;
    case (state_q)
      StIdle:  if (start) state_d = StCheck;
      StCheck: if (output2 != 32'd0) state_d = StInit;
      StInit: begin
        state_d   = StTest;
        iter_d    = '0;
        timeout_d = 1'b0;
      end
      StTest: begin
        if (!output5[0]) begin
          state_d = StFinal;
        end else if (iter_q < MaxIter) begin
          state_d = StLoop;
        end else begin
          // Runaway loop: abort straight to DONE without finalizing.
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end
      StLoop: begin
        state_d = StTest;
        iter_d  = iter_q + 1'b1;
      end
      StFinal: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign Enable3     = (state_q == StInit);
  assign Enable6     = (state_q == StLoop);
  assign Enable7     = (state_q == StFinal);
  assign done        = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign timeout_err = timeout_q;
  assign iter_count  = iter_q;

`ifdef DATA_PATH_CTRL_DBG_EN
  logic [31:0] dbg_cycles_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_cycles_q <= '0;
    end else if (state_q == StInit) begin
      dbg_cycles_q <= '0;
    end else if (busy && (dbg_cycles_q != 32'hFFFF_FFFF)) begin
      dbg_cycles_q <= dbg_cycles_q + 32'd1;
    end
  end

  assign dbg_state  = state_q;
  assign dbg_cycles = dbg_cycles_q;
`endif

endmodule
